// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_RD_LAT = 3;
    localparam int DEF_WR_LAT = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module wait_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign count = count_reg;
    assign zero  = (count_reg == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory between instruction fetch and load/store,
// with one outstanding transaction and the memory's wait-state timing owned here.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = DEF_RD_LAT,
    parameter int WR_LAT = DEF_WR_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(max_int(RD_LAT, WR_LAT) + 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT);

    state_t            state_reg, state_next;
    owner_t            owner_reg, last_grant_reg, grant_owner;
    logic              write_reg;
    logic              grant, finish;
    logic              cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]  cnt_load_val, cnt_val;
    logic              if_ack_reg, d_ack_reg, mem_we_reg;
    logic [DATA_W-1:0] if_rdata_reg, d_rdata_reg, mem_wdata_reg;
    logic [ADDR_W-1:0] mem_addr_reg;

    always_comb begin
        grant_owner = OWN_IF;
        if (if_req && d_req) begin
            grant_owner = (last_grant_reg == OWN_IF) ? OWN_D : OWN_IF;
        end else if (d_req) begin
            grant_owner = OWN_D;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Counter loads the full latency so BUSY spans LAT+1 cycles: read data is
    // sampled RD_LAT cycles after mem_addr updates, and the ack follows that.
    always_comb begin
        state_next   = state_reg;
        grant        = 1'b0;
        finish       = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = RD_LOAD;
        case (state_reg)
            IDLE: begin
                if (if_req || d_req) begin
                    grant        = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = (grant_owner == OWN_D && d_we) ? WR_LOAD : RD_LOAD;
                    state_next   = BUSY;
                end
            end
            BUSY: begin
                if (cnt_zero) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    wait_counter #(.W(CNT_W)) u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_reg      <= OWN_IF;
            last_grant_reg <= OWN_D;
            write_reg      <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_we_reg     <= 1'b0;
            if_rdata_reg   <= '0;
            d_rdata_reg    <= '0;
            if_ack_reg     <= 1'b0;
            d_ack_reg      <= 1'b0;
        end else begin
            if_ack_reg <= 1'b0;
            d_ack_reg  <= 1'b0;
            if (grant) begin
                owner_reg      <= grant_owner;
                last_grant_reg <= grant_owner;
                if (grant_owner == OWN_D) begin
                    mem_addr_reg  <= d_addr;
                    mem_wdata_reg <= d_wdata;
                    mem_we_reg    <= d_we;
                    write_reg     <= d_we;
                end else begin
                    mem_addr_reg <= if_addr;
                    mem_we_reg   <= 1'b0;
                    write_reg    <= 1'b0;
                end
            end
            // Write strobe ends one cycle before completion so it lasts WR_LAT cycles.
            if (state_reg == BUSY && cnt_val == CNT_W'(1)) begin
                mem_we_reg <= 1'b0;
            end
            if (finish) begin
                mem_we_reg <= 1'b0;
                if (owner_reg == OWN_D) begin
                    d_ack_reg <= 1'b1;
                    if (!write_reg) begin
                        d_rdata_reg <= mem_rdata;
                    end
                end else begin
                    if_ack_reg   <= 1'b1;
                    if_rdata_reg <= mem_rdata;
                end
            end
        end
    end

    assign if_ack    = if_ack_reg;
    assign d_ack     = d_ack_reg;
    assign if_rdata  = if_rdata_reg;
    assign d_rdata   = d_rdata_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_we    = mem_we_reg;
    assign busy      = (state_reg != IDLE);

endmodule
